// File: rtl/uart_cmd_rx.sv
// UART command framer: SYNC, ADDR, data bytes (MSB first), optional CHK.
// Define UART_CMD_CHKSUM_EN to require the trailing XOR checksum byte.
module uart_cmd_rx #(
   parameter int         NUM_WORDS      = 4,
   parameter int         WORD_BYTES     = 2,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1200000
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               received,
   input  logic [7:0]                         rx_byte,
   input  logic                               recv_error,
   input  logic                               is_transmitting,
   output logic                               transmit,
   output logic [7:0]                         tx_byte,
   output logic [NUM_WORDS*8*WORD_BYTES-1:0]  regs,
   output logic                               wr_stb,
   output logic [7:0]                         wr_addr,
   output logic                               busy,
   output logic                               err_timeout
);

   localparam int         W     = 8 * WORD_BYTES;
   localparam int         RW    = NUM_WORDS * W;
   localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] CNT_LAST = 3'(WORD_BYTES - 1);
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_CHK,
      S_COMMIT
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    addr_q, addr_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    xor_q, xor_d;
   logic          chk_ok_q, chk_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] regs_q, regs_d;
   logic          wr_stb_q, wr_stb_d;
   logic [7:0]    wr_addr_q, wr_addr_d;
   logic          pend_q, pend_d;
   logic [7:0]    pend_byte_q, pend_byte_d;
   logic          tmo_err_q, tmo_err_d;
   logic          in_frame;
   logic          expire;
   logic          abort_err;
   logic          in_range;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         xor_q       <= '0;
         chk_ok_q    <= 1'b0;
         tmo_q       <= '0;
         regs_q      <= '0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         pend_q      <= 1'b0;
         pend_byte_q <= '0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         xor_q       <= xor_d;
         chk_ok_q    <= chk_ok_d;
         tmo_q       <= tmo_d;
         regs_q      <= regs_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      xor_d       = xor_q;
      chk_ok_d    = chk_ok_q;
      regs_d      = regs_q;
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      pend_d      = pend_q;
      pend_byte_d = pend_byte_q;
      tmo_err_d   = 1'b0;
      transmit    = pend_q && !is_transmitting;
      in_frame    = (state_q == S_ADDR) || (state_q == S_DATA) ||
                    (state_q == S_CHK);
      expire      = in_frame && !received && (tmo_q == TMO_LAST);
      abort_err   = in_frame && recv_error;
      in_range    = {1'b0, addr_q} < 9'(NUM_WORDS);

      if (transmit) pend_d = 1'b0;

      // The counter only runs inside a frame; any byte restarts it.
      if (received || state_q == S_IDLE) tmo_d = '0;
      else tmo_d = tmo_q + TW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (received && rx_byte == SYNC_BYTE) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (received) begin
               addr_d  = rx_byte;
               xor_d   = rx_byte;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (received) begin
               acc_d = (acc_q << 8) | W'(rx_byte);
               xor_d = xor_q ^ rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == CNT_LAST) begin
`ifdef UART_CMD_CHKSUM_EN
                  state_d = S_CHK;
`else
                  chk_ok_d = 1'b1;
                  state_d  = S_COMMIT;
`endif
               end
            end
         end
         S_CHK: begin
            if (received) begin
               chk_ok_d = (rx_byte == xor_q);
               state_d  = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
            pend_d  = 1'b1;
            if (chk_ok_q && in_range) begin
               for (int k = 0; k < NUM_WORDS; k++) begin
                  if (addr_q == 8'(k)) regs_d[k*W +: W] = acc_q;
               end
               wr_stb_d    = 1'b1;
               wr_addr_d   = addr_q;
               pend_byte_d = ACK;
            end else begin
               pend_byte_d = NAK;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_err) begin
         state_d     = S_IDLE;
         pend_d      = 1'b1;
         pend_byte_d = NAK;
      end else if (expire) begin
         state_d   = S_IDLE;
         tmo_err_d = 1'b1;
      end
   end

   assign tx_byte     = pend_byte_q;
   assign regs        = regs_q;
   assign wr_stb      = wr_stb_q;
   assign wr_addr     = wr_addr_q;
   assign busy        = (state_q != S_IDLE);
   assign err_timeout = tmo_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: vector table plus multi-cycle sequences.
// Adapts frame length and expectations to UART_CMD_CHKSUM_EN.
module tb_uart_cmd_rx;

   localparam int NW = 4;
   localparam int WB = 2;

`ifdef UART_CMD_CHKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          received = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          recv_error = 1'b0;
   logic          is_transmitting = 1'b0;
   logic          transmit;
   logic [7:0]    tx_byte;
   logic [63:0]   regs;
   logic          wr_stb;
   logic [7:0]    wr_addr;
   logic          busy;
   logic          err_timeout;

   int n_chk = 0;
   int n_err = 0;
   int n_tx  = 0;
   int n_wr  = 0;
   int n_tmo = 0;
   logic [7:0] last_tx = 8'h00;

   uart_cmd_rx #(
      .NUM_WORDS(NW),
      .WORD_BYTES(WB),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .received(received),
      .rx_byte(rx_byte),
      .recv_error(recv_error),
      .is_transmitting(is_transmitting),
      .transmit(transmit),
      .tx_byte(tx_byte),
      .regs(regs),
      .wr_stb(wr_stb),
      .wr_addr(wr_addr),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (transmit) begin
         n_tx++;
         last_tx = tx_byte;
      end
      if (wr_stb) n_wr++;
      if (err_timeout) n_tmo++;
   end

   typedef struct {
      logic [39:0] bytes;
      logic [63:0] exp_regs;
      int          exp_nwr;
      logic [7:0]  exp_addr;
      logic [7:0]  exp_tx;
   } vec_t;

   vec_t v[4];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      received = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      received = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int b_tx, b_wr, b_tmo;
      logic [15:0] w1;

`ifdef UART_CMD_CHKSUM_EN
      w1 = 16'h0000;
      v[0] = '{40'hA5_02_12_34_24, 64'h0000_1234_0000_0000, 1, 8'h02, 8'h06};
      v[1] = '{40'hA5_01_AB_CD_00, 64'h0000_1234_0000_0000, 0, 8'h00, 8'h15};
      v[2] = '{40'hA5_05_00_01_04, 64'h0000_1234_0000_0000, 0, 8'h00, 8'h15};
      v[3] = '{40'hA5_03_A5_A5_03, 64'hA5A5_1234_0000_0000, 1, 8'h03, 8'h06};
`else
      w1 = 16'hABCD;
      v[0] = '{40'hA5_02_12_34_00, 64'h0000_1234_0000_0000, 1, 8'h02, 8'h06};
      v[1] = '{40'hA5_01_AB_CD_00, 64'h0000_1234_ABCD_0000, 1, 8'h01, 8'h06};
      v[2] = '{40'hA5_05_00_01_00, 64'h0000_1234_ABCD_0000, 0, 8'h00, 8'h15};
      v[3] = '{40'hA5_03_A5_A5_00, 64'hA5A5_1234_ABCD_0000, 1, 8'h03, 8'h06};
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_regs", regs, 64'h0);
      check("rst_tx_byte", {56'h0, tx_byte}, 64'h0);
      check("rst_wr_addr", {56'h0, wr_addr}, 64'h0);
      check("rst_transmit", {63'h0, transmit}, 64'h0);
      check("rst_wr_stb", {63'h0, wr_stb}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_err_tmo", {63'h0, err_timeout}, 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         b_tx = n_tx;
         b_wr = n_wr;
         for (int j = 0; j < NB; j++) send(v[i].bytes[39-8*j -: 8]);
         repeat (10) @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_regs", i), regs, v[i].exp_regs);
         check($sformatf("v%0d_nwr", i), 64'(n_wr - b_wr),
               64'(v[i].exp_nwr));
         if (v[i].exp_nwr > 0)
            check($sformatf("v%0d_addr", i), {56'h0, wr_addr},
                  {56'h0, v[i].exp_addr});
         check($sformatf("v%0d_ntx", i), 64'(n_tx - b_tx), 64'd1);
         check($sformatf("v%0d_tx", i), {56'h0, last_tx},
               {56'h0, v[i].exp_tx});
         check($sformatf("v%0d_busy", i), {63'h0, busy}, 64'h0);
      end

      // Partial frame left to time out, then a clean frame.
      b_tx  = n_tx;
      b_tmo = n_tmo;
      send(8'hA5);
      check("busy_after_sync", {63'h0, busy}, 64'h1);
      send(8'h03);
      send(8'h77);
      repeat (900) @(posedge clk);
      @(negedge clk);
      check("tmo_early", 64'(n_tmo - b_tmo), 64'd0);
      check("tmo_busy_hold", {63'h0, busy}, 64'h1);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (n_tmo != b_tmo) break;
      end
      repeat (3) @(negedge clk);
      check("tmo_pulses", 64'(n_tmo - b_tmo), 64'd1);
      check("tmo_busy", {63'h0, busy}, 64'h0);
      check("tmo_no_tx", 64'(n_tx - b_tx), 64'd0);
      send(8'hA5);
      send(8'h03);
      send(8'h11);
      send(8'h22);
`ifdef UART_CMD_CHKSUM_EN
      send(8'h30);
`endif
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("tmo_recover_regs", regs, {16'h1122, 16'h1234, w1, 16'h0000});
      check("tmo_recover_tx", {56'h0, last_tx}, 64'h06);

      // Response held off by a busy transmitter.
      b_tx = n_tx;
      send(8'h00);
      send(8'hFF);
      send(8'hA5);
      send(8'h00);
      send(8'h55);
      #1;
      is_transmitting = 1'b1;
      send(8'hAA);
`ifdef UART_CMD_CHKSUM_EN
      send(8'hFF);
`endif
      repeat (50) @(posedge clk);
      @(negedge clk);
      check("hold_no_tx", 64'(n_tx - b_tx), 64'd0);
      check("hold_regs", regs, {16'h1122, 16'h1234, w1, 16'h55AA});
      @(posedge clk);
      #1;
      is_transmitting = 1'b0;
      @(negedge clk);
      check("hold_transmit", {63'h0, transmit}, 64'h1);
      check("hold_tx_byte", {56'h0, tx_byte}, 64'h06);
      repeat (5) @(negedge clk);
      check("hold_ntx", 64'(n_tx - b_tx), 64'd1);

      // Receive error mid-frame, then in IDLE.
      b_tx = n_tx;
      b_wr = n_wr;
      send(8'hA5);
      send(8'h01);
      @(posedge clk);
      #1;
      recv_error = 1'b1;
      @(posedge clk);
      #1;
      recv_error = 1'b0;
      repeat (5) @(negedge clk);
      check("rerr_ntx", 64'(n_tx - b_tx), 64'd1);
      check("rerr_tx", {56'h0, last_tx}, 64'h15);
      check("rerr_busy", {63'h0, busy}, 64'h0);
      check("rerr_nwr", 64'(n_wr - b_wr), 64'd0);
      b_tx = n_tx;
      @(posedge clk);
      #1;
      recv_error = 1'b1;
      @(posedge clk);
      #1;
      recv_error = 1'b0;
      repeat (5) @(negedge clk);
      check("rerr_idle_ntx", 64'(n_tx - b_tx), 64'd0);

      // Reset in the middle of a frame.
      b_tx = n_tx;
      send(8'hA5);
      send(8'h01);
      send(8'h10);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_regs", regs, 64'h0);
      check("mrst_busy", {63'h0, busy}, 64'h0);
      check("mrst_wr_addr", {56'h0, wr_addr}, 64'h0);
      check("mrst_tx_byte", {56'h0, tx_byte}, 64'h0);
      check("mrst_transmit", {63'h0, transmit}, 64'h0);
      repeat (10) @(negedge clk);
      check("mrst_ntx", 64'(n_tx - b_tx), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
